cordic_arbiter: RTL and testbench

Shares one `cordic64` magnitude/phase pipeline between `C_NUM_CH` AXI-Stream requesters (per-antenna or per-channel IQ streams). Grants are round-robin and packet-atomic: a granted channel holds the pipeline until it sends `tlast`. Each beat carries a channel tag through a shift register that runs in lockstep with the CORDIC pipeline. Results leave on a single AXI-Stream master with the originating channel on `tuser`.

---
 rtl/cordic_arb_pkg.sv | 22 ++
 rtl/cordic_arbiter_rr_arbiter.sv | 34 +++
 rtl/cordic_arbiter.sv | 140 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC channel arbiter.
// Provides the tag carried alongside each beat through the CORDIC pipeline,
// the arbiter FSM state encoding and the default pipeline depth.
package cordic_arb_pkg;

    // Default CORDIC depth in enabled cycles (iterations + 1).
    localparam int unsigned C_CORDIC_LATENCY = 17;

    // Tag id width sized for the largest supported channel count (8).
    localparam int unsigned C_TAG_ID_WIDTH = 3;

    typedef struct packed {
        logic                      valid;
        logic [C_TAG_ID_WIDTH-1:0] id;
    } tag_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cordic_arbiter_rr_arbiter.sv
// Combinational round-robin grant.
// Ports: req (request mask), last_grant (previous winner),
//        gnt_id (winning channel), gnt_valid (any request present).
// The search starts at last_grant+1 and wraps, so last_grant has lowest priority.
module rr_arbiter #(
    parameter int unsigned C_NUM_CH   = 4,
    parameter int unsigned C_ID_WIDTH = 2
) (
    input  logic [C_NUM_CH-1:0]   req,
    input  logic [C_ID_WIDTH-1:0] last_grant,
    output logic [C_ID_WIDTH-1:0] gnt_id,
    output logic                  gnt_valid
);

    int unsigned idx;

    // Walk from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_id    = last_grant;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int i = int'(C_NUM_CH); i >= 1; i--) begin
            idx = 32'(last_grant) + 32'(i);
            if (idx >= C_NUM_CH) begin
                idx = idx - C_NUM_CH;
            end
            if (req[idx]) begin
                gnt_id    = C_ID_WIDTH'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC magnitude/phase pipeline between C_NUM_CH AXI-Stream
// requesters with packet-atomic round-robin grants.
// Ports:
//   s00_axis_*  per-channel slave streams (tvalid/tlast/tready per channel,
//               tdata packed with channel k at slice k)
//   cor_s_*     beats towards the CORDIC slave
//   cor_m_*     results from the CORDIC master; cor_m_tready is the pipe enable
//   m00_axis_*  merged result stream, tuser = originating channel
//   tag_err     sticky: CORDIC output valid disagrees with the tag pipe
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int unsigned C_NUM_CH      = 4,
    parameter int unsigned C_TDATA_WIDTH = 64,
    parameter int unsigned C_LATENCY     = C_CORDIC_LATENCY,
    parameter int unsigned C_ID_WIDTH    = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic [C_NUM_CH-1:0]                 s00_axis_tvalid,
    input  logic [C_NUM_CH*C_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_NUM_CH-1:0]                 s00_axis_tlast,
    output logic [C_NUM_CH-1:0]                 s00_axis_tready,
    output logic                                cor_s_tvalid,
    output logic                                cor_s_tlast,
    output logic [C_TDATA_WIDTH-1:0]            cor_s_tdata,
    input  logic                                cor_s_tready,
    input  logic                                cor_m_tvalid,
    input  logic                                cor_m_tlast,
    input  logic [C_TDATA_WIDTH-1:0]            cor_m_tdata,
    output logic                                cor_m_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_TDATA_WIDTH-1:0]            m00_axis_tdata,
    output logic [C_ID_WIDTH-1:0]               m00_axis_tuser,
    input  logic                                m00_axis_tready,
    output logic                                tag_err
);

    localparam int unsigned CNT_W = $clog2(C_LATENCY + 1);

    arb_state_t            state, state_next;
    logic [C_ID_WIDTH-1:0] lock_id, lock_next;
    logic [C_ID_WIDTH-1:0] last_grant, last_next;
    logic [C_ID_WIDTH-1:0] rr_gnt, grant;
    logic                  rr_valid, gnt_valid, accept;
    tag_t                  pipe [C_LATENCY];
    tag_t                  tail;
    logic [CNT_W-1:0]      flush_cnt;

    rr_arbiter #(
        .C_NUM_CH   (C_NUM_CH),
        .C_ID_WIDTH (C_ID_WIDTH)
    ) u_rr (
        .req        (s00_axis_tvalid),
        .last_grant (last_grant),
        .gnt_id     (rr_gnt),
        .gnt_valid  (rr_valid)
    );

    // FSM state register.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state      <= ST_IDLE;
            lock_id    <= '0;
            last_grant <= C_ID_WIDTH'(C_NUM_CH - 1);
        end else begin
            state      <= state_next;
            lock_id    <= lock_next;
            last_grant <= last_next;
        end
    end

    // Grant selection, slave-side mux and next-state; nothing is granted in reset.
    always_comb begin
        state_next      = state;
        lock_next       = lock_id;
        last_next       = last_grant;
        grant           = rr_gnt;
        gnt_valid       = rr_valid && s00_axis_aresetn;
        s00_axis_tready = '0;
        if (state == ST_LOCKED) begin
            grant     = lock_id;
            gnt_valid = s00_axis_aresetn;
        end
        accept       = gnt_valid && s00_axis_tvalid[grant] && cor_s_tready;
        cor_s_tvalid = gnt_valid && s00_axis_tvalid[grant];
        cor_s_tlast  = s00_axis_tlast[grant];
        cor_s_tdata  = s00_axis_tdata[32'(grant) * C_TDATA_WIDTH +: C_TDATA_WIDTH];
        if (gnt_valid && cor_s_tready) begin
            s00_axis_tready[grant] = 1'b1;
        end
        if (accept) begin
            if (s00_axis_tlast[grant]) begin
                state_next = ST_IDLE;
                last_next  = grant;
            end else begin
                state_next = ST_LOCKED;
                lock_next  = grant;
            end
        end
    end

    // Tag shift register in lockstep with the CORDIC pipeline enable.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 0; i < int'(C_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else if (m00_axis_tready) begin
            pipe[0] <= '{valid: accept, id: C_TAG_ID_WIDTH'(grant)};
            for (int i = 1; i < int'(C_LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Enabled-cycle count since reset; the CORDIC holds stale data until it saturates.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            flush_cnt <= '0;
            tag_err   <= 1'b0;
        end else if (m00_axis_tready) begin
            if (flush_cnt != CNT_W'(C_LATENCY)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else if (tail.valid != cor_m_tvalid) begin
                tag_err <= 1'b1;
            end
        end
    end

    assign tail            = pipe[C_LATENCY-1];
    assign cor_m_tready    = m00_axis_tready;
    // Valid comes from the tag pipe: the CORDIC has no reset.
    assign m00_axis_tvalid = tail.valid;
    assign m00_axis_tuser  = C_ID_WIDTH'(tail.id);
    assign m00_axis_tdata  = cor_m_tdata;
    assign m00_axis_tlast  = cor_m_tlast;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a stand-in CORDIC (no reset, exact magnitude in
// bits 31:0, Q carried in bits 63:32) plus a packet-level round-robin model.
module tb_cordic_arbiter;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int L   = 17;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]   s_tvalid, s_tlast, s_tready;
    logic [N*W-1:0] s_tdata;
    logic           cs_tvalid, cs_tlast, cs_tready;
    logic [W-1:0]   cs_tdata;
    logic           cm_tvalid, cm_tlast, cm_tready;
    logic [W-1:0]   cm_tdata;
    logic           m_tvalid, m_tlast, m_tready;
    logic [W-1:0]   m_tdata;
    logic [IDW-1:0] m_tuser;
    logic           tag_err;
    logic           force_v = 1'b0;

    always #5 clk = ~clk;

    cordic_arbiter #(.C_NUM_CH(N), .C_TDATA_WIDTH(W), .C_LATENCY(L)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata),
        .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready),
        .cor_s_tvalid(cs_tvalid), .cor_s_tlast(cs_tlast), .cor_s_tdata(cs_tdata),
        .cor_s_tready(cs_tready),
        .cor_m_tvalid(cm_tvalid), .cor_m_tlast(cm_tlast), .cor_m_tdata(cm_tdata),
        .cor_m_tready(cm_tready),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
        .m00_axis_tdata(m_tdata), .m00_axis_tuser(m_tuser),
        .m00_axis_tready(m_tready), .tag_err(tag_err)
    );

    // CORDIC accepts whenever its pipeline is enabled.
    assign cs_tready = m_tready;

    function automatic logic [63:0] cordic_f(input logic [63:0] d);
        longint i, q, v, r;
        i = longint'($signed(d[31:0]));
        q = longint'($signed(d[63:32]));
        v = i * i + q * q;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return {d[63:32], 32'(r)};
    endfunction

    // Stand-in CORDIC with no reset: starts full of garbage valid beats.
    logic         cv [L];
    logic         cl [L];
    logic [W-1:0] cd [L];
    bit           filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            filled <= 1'b1;
            for (int i = 0; i < L; i++) begin
                cv[i] <= 1'b1;
                cl[i] <= 1'b1;
                cd[i] <= {$urandom, $urandom};
            end
        end else if (cm_tready) begin
            cv[0] <= cs_tvalid && cs_tready;
            cl[0] <= cs_tlast;
            cd[0] <= cordic_f(cs_tdata);
            for (int i = 1; i < L; i++) begin
                cv[i] <= cv[i-1];
                cl[i] <= cl[i-1];
                cd[i] <= cd[i-1];
            end
        end
    end
    assign cm_tvalid = cv[L-1] | force_v;
    assign cm_tlast  = cl[L-1];
    assign cm_tdata  = cd[L-1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed { logic [63:0] d; logic l; } beat_t;
    typedef struct { int ch; logic [63:0] d; logic l; } exp_t;

    beat_t  q [N][$];
    exp_t   expq [$];
    bit     mid [N];
    bit     bubbles = 1'b0;
    bit     rnd_ready = 1'b0;
    int     model_last = N - 1;
    int     cyc = 0;
    logic [N-1:0] fire;
    int     out_cyc [$];
    logic [31:0] out_mag [$];
    int     acc_ch [$];
    int     acc_cy [$];
    int     rdy_viol = 0;
    int     rst_viol = 0;

    // Whole-packet round-robin over channels that still hold packets.
    task automatic plan();
        int ptr [N];
        int c;
        beat_t b;
        for (int k = 0; k < N; k++) ptr[k] = 0;
        while (1) begin
            c = -1;
            for (int i = 1; i <= N; i++) begin
                int cc = (model_last + i) % N;
                if (c < 0 && ptr[cc] < q[cc].size()) c = cc;
            end
            if (c < 0) break;
            while (1) begin
                b = q[c][ptr[c]];
                ptr[c]++;
                expq.push_back('{ch: c, d: cordic_f(b.d), l: b.l});
                if (b.l) break;
            end
            model_last = c;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (q[k].size() > 0) begin
                s_tvalid[k] = !mid[k] || !bubbles || ($urandom % 4 != 0);
                s_tdata[k*W +: W] = q[k][0].d;
                s_tlast[k] = q[k][0].l;
            end else begin
                s_tvalid[k] = 1'b0;
                s_tdata[k*W +: W] = '0;
                s_tlast[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        fire = s_tvalid & s_tready;
        if (!m_tready && s_tready != '0) rdy_viol++;
        if (!rst_n && (m_tvalid || s_tready != '0)) rst_viol++;
        for (int k = 0; k < N; k++) begin
            if (fire[k]) begin
                acc_ch.push_back(k);
                acc_cy.push_back(cyc);
            end
        end
        if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
                check("unexpected_out", 64'(m_tuser), 64'hFFFF);
            end else begin
                e = expq.pop_front();
                check("out_tuser", 64'(m_tuser), 64'(e.ch));
                check("out_tdata", m_tdata, e.d);
                check("out_tlast", 64'(m_tlast), 64'(e.l));
                out_cyc.push_back(cyc);
                out_mag.push_back(m_tdata[31:0]);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (fire[k] && q[k].size() > 0) begin
                beat_t b = q[k].pop_front();
                mid[k] = !b.l;
            end
        end
        drive();
        m_tready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (expq.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_left", 64'(expq.size()), 64'd0);
        repeat (L + 2) tick();
    endtask

    function automatic logic [63:0] iq(input int i, input int qv);
        return {32'(qv), 32'(i)};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        for (int k = 0; k < N; k++) mid[k] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset with a garbage-filled CORDIC.
        repeat (20) tick();
        check("reset_outputs", 64'(rst_viol), 64'd0);
        check("idle_tag_err", 64'(tag_err), 64'd0);

        // Four single-beat packets, all valid together.
        q[0].push_back('{d: iq(3, 4), l: 1'b1});
        q[1].push_back('{d: iq(0, 5), l: 1'b1});
        q[2].push_back('{d: iq(-6, 8), l: 1'b1});
        q[3].push_back('{d: iq(1, 0), l: 1'b1});
        plan();
        out_cyc.delete(); out_mag.delete();
        drive();
        cyc0 = cyc;
        drain(200);
        check("dir_count", 64'(out_cyc.size()), 64'd4);
        if (out_cyc.size() == 4) begin
            check("dir_first_lat", 64'(out_cyc[0] - cyc0), 64'd17);
            check("dir_last_lat", 64'(out_cyc[3] - cyc0), 64'd20);
            check("dir_mag0", 64'(out_mag[0]), 64'd5);
            check("dir_mag1", 64'(out_mag[1]), 64'd5);
            check("dir_mag2", 64'(out_mag[2]), 64'd10);
            check("dir_mag3", 64'(out_mag[3]), 64'd1);
        end

        // Packet atomicity: ch1 4-beat packet while ch2 waits.
        for (int b = 0; b < 4; b++) q[1].push_back('{d: iq(b + 1, -b), l: (b == 3)});
        q[2].push_back('{d: iq(7, 7), l: 1'b1});
        plan();
        acc_ch.delete(); acc_cy.delete();
        drive();
        drain(200);
        check("lock_acc_count", 64'(acc_ch.size()), 64'd5);
        if (acc_ch.size() == 5) begin
            check("lock_order3", 64'(acc_ch[3]), 64'd1);
            check("lock_ch2_next", 64'(acc_ch[4]), 64'd2);
            check("lock_ch2_gap", 64'(acc_cy[4] - acc_cy[3]), 64'd1);
        end

        // Random traffic with bubbles and 50% downstream ready.
        bubbles = 1'b1;
        rnd_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < 3; p++) begin
                int len = 1 + int'($urandom % 4);
                for (int b = 0; b < len; b++) begin
                    int iv = int'($urandom_range(2000)) - 1000;
                    int qv = int'($urandom_range(2000)) - 1000;
                    q[k].push_back('{d: iq(iv, qv), l: (b == len - 1)});
                end
            end
        end
        plan();
        rdy_viol = 0;
        drive();
        drain(4000);
        check("rdy_low_viol", 64'(rdy_viol), 64'd0);
        rnd_ready = 1'b0;
        bubbles = 1'b0;
        m_tready = 1'b1;
        repeat (L + 2) tick();

        // Reset in the middle of a channel-3 packet.
        for (int b = 0; b < 5; b++) q[3].push_back('{d: iq(9, b), l: (b == 4)});
        acc_ch.delete(); acc_cy.delete();
        drive();
        begin
            int n = 0;
            while (acc_ch.size() < 2 && n < 50) begin
                tick();
                n++;
            end
        end
        check("mid_pkt_accepts", 64'(acc_ch.size()), 64'd2);
        rst_n = 1'b0;
        rst_viol = 0;
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            mid[k] = 1'b0;
        end
        model_last = N - 1;
        drive();
        repeat (2) tick();
        check("mid_rst_outputs", 64'(rst_viol), 64'd0);
        rst_n = 1'b1;
        q[3].push_back('{d: iq(2, 2), l: 1'b1});
        q[0].push_back('{d: iq(4, 3), l: 1'b1});
        plan();
        acc_ch.delete(); acc_cy.delete();
        drive();
        drain(200);
        check("post_rst_count", 64'(acc_ch.size()), 64'd2);
        if (acc_ch.size() == 2) check("post_rst_first", 64'(acc_ch[0]), 64'd0);
        check("post_rst_tag_err", 64'(tag_err), 64'd0);

        // Spurious CORDIC valid after flush sets the sticky error.
        force_v = 1'b1;
        tick();
        force_v = 1'b0;
        tick();
        check("tag_err_set", 64'(tag_err), 64'd1);
        repeat (5) tick();
        check("tag_err_sticky", 64'(tag_err), 64'd1);
        rst_n = 1'b0;
        tick();
        check("tag_err_reset", 64'(tag_err), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
